// File: rtl/spi_reg_ctrl_if.sv
// Register-bus bundle between the SPI register controller (master) and a register file (slave).
interface spi_reg_ctrl_if #(
    parameter int ADDR_W = 6
);
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic              reg_we;
    logic              reg_re;
    logic [7:0]        reg_rdata;

    modport master (
        output reg_addr, reg_wdata, reg_we, reg_re,
        input  reg_rdata
    );

    modport slave (
        input  reg_addr, reg_wdata, reg_we, reg_re,
        output reg_rdata
    );
endinterface

// File: rtl/spi_reg_ctrl.sv
// SPI byte-stream to register-bus bridge: command byte (R/nW, AINC, address) followed by
// data bytes that are written, or dummy bytes that clock out read data.
module spi_reg_ctrl #(
    parameter int ADDR_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs_n,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_byte_ready,
    output logic [7:0]            tx_byte,
    spi_reg_ctrl_if.master        reg_bus,
    output logic                  busy,
    output logic                  frame_done
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] CMD      = 3'd1;
    localparam logic [2:0] WRITE    = 3'd2;
    localparam logic [2:0] RD_FETCH = 3'd3;
    localparam logic [2:0] READ     = 3'd4;

    logic [2:0]        state;
    logic              cs_s1, cs_s2;
    logic [1:0]        sync_vld;
    logic              cs_act, cs_act_d, cs_block;
    logic              rdy_d;
    logic              byte_evt, byte_ok, cs_rise;
    logic [ADDR_W-1:0] addr, addr_q, addr_mux;
    logic [7:0]        wdata_q, wdata_mux;
    logic              ainc, cmd_seen;
    logic              we, re;

    // cs_block keeps a frame already in progress at reset release from being entered:
    // it clears only once the synchronizer has carried a real cs_n=1 sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cs_s1    <= 1'b1;
            cs_s2    <= 1'b1;
            sync_vld <= '0;
            cs_act_d <= 1'b0;
            cs_block <= 1'b1;
            rdy_d    <= 1'b0;
        end else begin
            cs_s1    <= cs_n;
            cs_s2    <= cs_s1;
            sync_vld <= {sync_vld[0], 1'b1};
            cs_act_d <= cs_act;
            if (sync_vld[1] && !cs_act)
                cs_block <= 1'b0;
            rdy_d    <= rx_byte_ready;
        end
    end

    assign cs_act   = ~cs_s2;
    assign cs_rise  = cs_act & ~cs_act_d & ~cs_block;
    assign byte_evt = rx_byte_ready & ~rdy_d;
    assign byte_ok  = byte_evt & cs_act;

    // Strobes are issued in the byte_evt cycle so read data is back during RD_FETCH.
    always_comb begin
        we        = 1'b0;
        re        = 1'b0;
        addr_mux  = addr_q;
        wdata_mux = wdata_q;
        if (byte_ok) begin
            case (state)
                CMD: begin
                    if (rx_byte[7]) begin
                        re       = 1'b1;
                        addr_mux = rx_byte[ADDR_W-1:0];
                    end
                end
                READ: begin
                    re       = 1'b1;
                    addr_mux = addr;
                end
                WRITE: begin
                    we        = 1'b1;
                    addr_mux  = addr;
                    wdata_mux = rx_byte;
                end
                default: ;
            endcase
        end
    end

    assign reg_bus.reg_we    = we;
    assign reg_bus.reg_re    = re;
    assign reg_bus.reg_addr  = addr_mux;
    assign reg_bus.reg_wdata = wdata_mux;
    assign busy              = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            tx_byte    <= '0;
            addr       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ainc       <= 1'b0;
            cmd_seen   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            addr_q     <= addr_mux;
            wdata_q    <= wdata_mux;
            if (state != IDLE && !cs_act) begin
                state      <= IDLE;
                tx_byte    <= '0;
                frame_done <= cmd_seen;
                cmd_seen   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        tx_byte  <= '0;
                        cmd_seen <= 1'b0;
                        if (cs_rise)
                            state <= CMD;
                    end
                    CMD: begin
                        if (byte_ok) begin
                            addr     <= rx_byte[ADDR_W-1:0];
                            ainc     <= rx_byte[6];
                            cmd_seen <= 1'b1;
                            state    <= rx_byte[7] ? RD_FETCH : WRITE;
                        end
                    end
                    RD_FETCH: begin
                        tx_byte <= reg_bus.reg_rdata;
                        addr    <= addr + ADDR_W'(ainc);
                        state   <= READ;
                    end
                    READ: begin
                        if (byte_ok)
                            state <= RD_FETCH;
                    end
                    WRITE: begin
                        if (byte_ok)
                            addr <= addr + ADDR_W'(ainc);
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: a byte-level SPI master model and a register file with
// one-cycle read latency.
module tb_spi_reg_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       cs_n;
    logic [7:0] rx_byte;
    logic       rx_byte_ready;
    logic [7:0] tx_byte;
    logic       busy;
    logic       frame_done;

    spi_reg_ctrl_if #(.ADDR_W(6)) bus ();

    spi_reg_ctrl #(.ADDR_W(6)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cs_n          (cs_n),
        .rx_byte       (rx_byte),
        .rx_byte_ready (rx_byte_ready),
        .tx_byte       (tx_byte),
        .reg_bus       (bus),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [64];
    logic [5:0]  we_addr_q [$];
    logic [7:0]  we_data_q [$];
    logic [5:0]  re_q [$];
    int unsigned fd_cnt = 0;
    int unsigned overlap_cnt = 0;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always @(posedge clk) begin
        if (bus.reg_we === 1'b1) begin
            mem[bus.reg_addr] <= bus.reg_wdata;
            we_addr_q.push_back(bus.reg_addr);
            we_data_q.push_back(bus.reg_wdata);
        end
        if (bus.reg_re === 1'b1) begin
            bus.reg_rdata <= mem[bus.reg_addr];
            re_q.push_back(bus.reg_addr);
        end
        if (bus.reg_we === 1'b1 && bus.reg_re === 1'b1)
            overlap_cnt <= overlap_cnt + 1;
        if (frame_done === 1'b1)
            fd_cnt <= fd_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // One byte slot: sample MISO byte early in the slot, then complete the byte.
    task automatic send_byte(input logic [7:0] b, output logic [7:0] tx_seen);
        repeat (4) @(negedge clk);
        tx_seen = tx_byte;
        repeat (12) @(negedge clk);
        rx_byte       = b;
        rx_byte_ready = 1'b1;
        repeat (2) @(negedge clk);
        rx_byte_ready = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_begin();
        cs_n = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic cs_end();
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        logic [7:0]  t;
        int unsigned w0, r0, f0;
        logic [5:0]  ea [4];
        logic [7:0]  ed [4];
        logic [7:0]  et [4];

        rst_n = 1'b0; cs_n = 1'b1; rx_byte = '0; rx_byte_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", tx_byte, 8'h00);
        check("rst_we", bus.reg_we, 1'b0);
        check("rst_re", bus.reg_re, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_fd", frame_done, 1'b0);
        check("rst_addr", bus.reg_addr, 6'd0);
        check("rst_wdata", bus.reg_wdata, 8'h00);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Single write: addr 5 <- 0xA7
        w0 = we_addr_q.size(); f0 = fd_cnt;
        cs_begin();
        check("busy_frame", busy, 1'b1);
        send_byte(8'h05, t); check("tx_cmd_slot", t, 8'h00);
        send_byte(8'hA7, t);
        cs_end();
        check("wr1_cnt", we_addr_q.size() - w0, 1);
        check("wr1_addr", we_addr_q[w0], 6'd5);
        check("wr1_data", we_data_q[w0], 8'hA7);
        check("wr1_fd", fd_cnt - f0, 1);
        check("wr1_busy", busy, 1'b0);
        check("wr1_addr_hold", bus.reg_addr, 6'd5);
        check("wr1_wdata_hold", bus.reg_wdata, 8'hA7);

        // Burst write with address wrap 62, 63, 0
        w0 = we_addr_q.size();
        ea = '{6'd62, 6'd63, 6'd0, 6'd0};
        ed = '{8'h11, 8'h22, 8'h33, 8'h00};
        cs_begin();
        send_byte(8'h7E, t);
        for (int i = 0; i < 3; i++) send_byte(ed[i], t);
        cs_end();
        check("wrap_cnt", we_addr_q.size() - w0, 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("wrap_addr%0d", i), we_addr_q[w0 + i], ea[i]);
            check($sformatf("wrap_data%0d", i), we_data_q[w0 + i], ed[i]);
        end

        // Preload regs 3..6 through the DUT, then burst-read from 3
        cs_begin();
        send_byte(8'h43, t);
        send_byte(8'h10, t); send_byte(8'h20, t); send_byte(8'h30, t); send_byte(8'h66, t);
        cs_end();
        w0 = we_addr_q.size(); r0 = re_q.size();
        et = '{8'h00, 8'h10, 8'h20, 8'h30};
        ea = '{6'd3, 6'd4, 6'd5, 6'd6};
        cs_begin();
        send_byte(8'hC3, t); check("brd_tx0", t, et[0]);
        for (int i = 1; i < 4; i++) begin
            send_byte(8'hFF, t);
            check($sformatf("brd_tx%0d", i), t, et[i]);
        end
        cs_end();
        check("brd_re_cnt", re_q.size() - r0, 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("brd_re_addr%0d", i), re_q[r0 + i], ea[i]);
        check("brd_no_we", we_addr_q.size() - w0, 0);
        check("brd_tx_idle", tx_byte, 8'h00);

        // No-increment read of reg 10
        cs_begin();
        send_byte(8'h0A, t); send_byte(8'h5A, t);
        cs_end();
        r0 = re_q.size();
        cs_begin();
        send_byte(8'h8A, t); check("nai_tx0", t, 8'h00);
        for (int i = 1; i < 4; i++) begin
            send_byte(8'h00, t);
            check($sformatf("nai_tx%0d", i), t, 8'h5A);
        end
        cs_end();
        check("nai_re_cnt", re_q.size() - r0, 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("nai_re_addr%0d", i), re_q[r0 + i], 6'd10);
        check("nai_addr_hold", bus.reg_addr, 6'd10);

        // Abort partway into a write data byte, then a normal frame
        w0 = we_addr_q.size(); f0 = fd_cnt;
        cs_begin();
        send_byte(8'h05, t);
        repeat (8) @(negedge clk);
        cs_end();
        check("abort_no_we", we_addr_q.size() - w0, 0);
        check("abort_fd", fd_cnt - f0, 1);
        check("abort_busy", busy, 1'b0);
        w0 = we_addr_q.size();
        cs_begin();
        send_byte(8'h45, t); send_byte(8'h99, t); send_byte(8'h98, t);
        cs_end();
        check("post_abort_cnt", we_addr_q.size() - w0, 2);
        check("post_abort_a0", we_addr_q[w0], 6'd5);
        check("post_abort_d0", we_data_q[w0], 8'h99);
        check("post_abort_a1", we_addr_q[w0 + 1], 6'd6);
        check("post_abort_d1", we_data_q[w0 + 1], 8'h98);

        // CS frame without any byte: no frame_done
        f0 = fd_cnt;
        cs_begin();
        repeat (10) @(negedge clk);
        cs_end();
        check("empty_fd", fd_cnt - f0, 0);

        // Byte while CS deasserted is ignored
        w0 = we_addr_q.size(); r0 = re_q.size();
        send_byte(8'h85, t);
        send_byte(8'h12, t);
        check("idle_byte_we", we_addr_q.size() - w0, 0);
        check("idle_byte_re", re_q.size() - r0, 0);
        check("idle_byte_busy", busy, 1'b0);

        // Reset during WRITE with CS held low
        w0 = we_addr_q.size(); r0 = re_q.size(); f0 = fd_cnt;
        cs_begin();
        send_byte(8'h05, t);
        check("pre_rst_busy", busy, 1'b1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst_tx", tx_byte, 8'h00);
        check("mid_rst_addr", bus.reg_addr, 6'd0);
        check("mid_rst_wdata", bus.reg_wdata, 8'h00);
        check("mid_rst_we", bus.reg_we, 1'b0);
        check("mid_rst_re", bus.reg_re, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_fd", frame_done, 1'b0);
        rst_n = 1'b1;
        send_byte(8'h07, t);
        send_byte(8'h55, t);
        send_byte(8'h87, t);
        check("post_rst_no_we", we_addr_q.size() - w0, 0);
        check("post_rst_no_re", re_q.size() - r0, 0);
        check("post_rst_busy", busy, 1'b0);
        cs_end();
        check("post_rst_fd", fd_cnt - f0, 0);
        w0 = we_addr_q.size();
        cs_begin();
        send_byte(8'h01, t); send_byte(8'h42, t);
        cs_end();
        check("recover_cnt", we_addr_q.size() - w0, 1);
        check("recover_addr", we_addr_q[w0], 6'd1);
        check("recover_data", we_data_q[w0], 8'h42);

        check("we_re_overlap", overlap_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
